mux_scan_ctrl: RTL and testbench

- Sequencer that sits in front of and behind mux_16x1. It drives the mux select lines and samples the mux output.
- On each start request it walks the select through all 16 channels, waits a settle time per channel, then samples y.
- The 16 samples are assembled into a parallel word. Completion is signalled with a one-cycle done pulse.
- Turns the combinational 16:1 mux into a timed serial-to-parallel channel scanner.

---
 rtl/mux_pkg.sv | 15 +
 rtl/mux_scan_ctrl.sv | 107 ++++++++++
 tb/tb_mux_scan_ctrl.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/mux_pkg.sv
// Shared constants and state encoding for the mux channel scanner.
package mux_pkg;

    localparam int MUX_NCH    = 16;
    localparam int MUX_SEL_W  = 4;
    localparam int MUX_SETTLE = 2;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_SETTLE = 2'd1;
    localparam state_t ST_SAMPLE = 2'd2;
    localparam state_t ST_DONE   = 2'd3;

endpackage

// File: rtl/mux_scan_ctrl.sv
// Walks a 16:1 mux select through every channel, waits a settle time per
// channel, samples y_in and publishes the assembled word with a done pulse.
//
// state  | meaning
// IDLE   | sel parked at 0, waiting for start
// SETTLE | select applied, counting down settle time
// SAMPLE | capture y_in into shadow bit, advance channel
// DONE   | data/done registered on entry, back to IDLE next edge
module mux_scan_ctrl
    import mux_pkg::*;
#(
    parameter int NCH    = MUX_NCH,
    parameter int SEL_W  = MUX_SEL_W,
    parameter int SETTLE = MUX_SETTLE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             y_in,
    output logic [SEL_W-1:0] sel,
    output logic [NCH-1:0]   data,
    output logic             busy,
    output logic             done
);

    localparam logic [3:0]       SETTLE_LD = 4'(SETTLE - 1);
    localparam logic [SEL_W-1:0] CH_LAST   = SEL_W'(NCH - 1);
    localparam logic [SEL_W-1:0] CH_ONE    = SEL_W'(1);

    state_t           state;
    logic [SEL_W-1:0] ch;
    logic [3:0]       settle_cnt;
    logic [NCH-1:0]   shadow;
    logic [NCH-1:0]   shadow_nxt;

    // The final channel's sample lands in data on the same edge it is taken.
    always_comb begin
        shadow_nxt     = shadow;
        shadow_nxt[ch] = y_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            ch         <= '0;
            settle_cnt <= '0;
            shadow     <= '0;
            sel        <= '0;
            data       <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    sel  <= '0;
                    busy <= 1'b0;
                    done <= 1'b0;
                    if (start && !abort) begin
                        state      <= ST_SETTLE;
                        ch         <= '0;
                        settle_cnt <= SETTLE_LD;
                        busy       <= 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (abort) begin
                        state <= ST_IDLE;
                        sel   <= '0;
                        busy  <= 1'b0;
                    end else if (settle_cnt == 4'd0) begin
                        state <= ST_SAMPLE;
                    end else begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end
                end
                ST_SAMPLE: begin
                    if (abort) begin
                        state <= ST_IDLE;
                        sel   <= '0;
                        busy  <= 1'b0;
                    end else begin
                        shadow <= shadow_nxt;
                        if (ch == CH_LAST) begin
                            state <= ST_DONE;
                            data  <= shadow_nxt;
                            done  <= 1'b1;
                        end else begin
                            ch         <= ch + CH_ONE;
                            sel        <= ch + CH_ONE;
                            settle_cnt <= SETTLE_LD;
                            state      <= ST_SETTLE;
                        end
                    end
                end
                default: begin
                    // DONE: abort here changes nothing, data already stands.
                    state <= ST_IDLE;
                    sel   <= '0;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Randomized self-checking bench for mux_scan_ctrl with SETTLE=2 and SETTLE=1 instances.
module tb_mux_scan_ctrl;
    import mux_pkg::*;

    localparam int NCH = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [15:0] mux_i;
    logic        start_r, abort_r;
    int          dsel;

    logic        start0, abort0, y0, busy0, done0;
    logic        start1, abort1, y1, busy1, done1;
    logic [3:0]  sel0, sel1;
    logic [15:0] data0, data1;

    logic        cur_busy, cur_done;
    logic [3:0]  cur_sel;
    logic [15:0] cur_data;

    assign start0 = (dsel == 0) && start_r;
    assign abort0 = (dsel == 0) && abort_r;
    assign start1 = (dsel == 1) && start_r;
    assign abort1 = (dsel == 1) && abort_r;
    assign y0 = mux_i[sel0];
    assign y1 = mux_i[sel1];
    assign cur_busy = (dsel == 1) ? busy1 : busy0;
    assign cur_done = (dsel == 1) ? done1 : done0;
    assign cur_sel  = (dsel == 1) ? sel1  : sel0;
    assign cur_data = (dsel == 1) ? data1 : data0;

    mux_scan_ctrl #(.NCH(16), .SEL_W(4), .SETTLE(2)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0), .y_in(y0),
        .sel(sel0), .data(data0), .busy(busy0), .done(done0));

    mux_scan_ctrl #(.NCH(16), .SEL_W(4), .SETTLE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .y_in(y1),
        .sel(sel1), .data(data1), .busy(busy1), .done(done1));

    int checks = 0;
    int failures = 0;
    logic [15:0] exp_data [2];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Latency model: NCH channels, each SETTLE wait cycles plus one sample cycle.
    function automatic int scan_lat(input int d);
        return NCH * ((d == 1 ? 1 : 2) + 1);
    endfunction

    task automatic run_scan(input int d, input logic [15:0] pat, input int abort_at, input bit noise);
        int s, lat, cyc, done_cnt, done_at;
        int selcnt [16];
        bit full, sel_ok;
        s = (d == 1) ? 1 : 2;
        lat = scan_lat(d);
        full = (abort_at < 0) || (abort_at >= lat);
        foreach (selcnt[k]) selcnt[k] = 0;
        @(negedge clk);
        dsel = d; mux_i = pat; start_r = 1'b1; abort_r = 1'b0;
        @(posedge clk);
        cyc = 0; done_cnt = 0; done_at = -1;
        while (cyc < lat + 4) begin
            @(negedge clk);
            if (cur_busy) selcnt[cur_sel]++;
            if (cur_done) begin
                done_cnt++;
                if (done_at < 0) done_at = cyc;
            end
            if (cyc == lat + 1) chk("busy_after_done", 32'(cur_busy), 32'd0);
            if (abort_at >= 0 && abort_at < lat && cyc == abort_at + 1) begin
                chk("abort_busy", 32'(cur_busy), 32'd0);
                chk("abort_sel", 32'(cur_sel), 32'd0);
            end
            start_r = (noise && abort_at < 0 && cyc <= lat) ? 1'($urandom_range(1, 0)) : 1'b0;
            abort_r = (cyc == abort_at);
            @(posedge clk);
            cyc++;
        end
        @(negedge clk);
        start_r = 1'b0; abort_r = 1'b0;
        if (full) begin
            exp_data[d] = pat;
            chk("done_count", 32'(done_cnt), 32'd1);
            chk("done_latency", 32'(done_at), 32'(lat));
            sel_ok = 1'b1;
            for (int k = 0; k < 16; k++)
                if (selcnt[k] != ((k == 15) ? s + 2 : s + 1)) sel_ok = 1'b0;
            chk("sel_dwell", 32'(sel_ok), 32'd1);
        end else begin
            chk("abort_no_done", 32'(done_cnt), 32'd0);
        end
        chk("scan_data", 32'(cur_data), 32'(exp_data[d]));
        chk("idle_sel", 32'(cur_sel), 32'd0);
    endtask

    initial begin
        int cyc, done_cnt, t1, t2, lat, bad;
        rst_n = 1'b1; start_r = 1'b0; abort_r = 1'b0; dsel = 0; mux_i = '0;
        exp_data[0] = '0; exp_data[1] = '0;
        #3 rst_n = 1'b0;
        #1;
        chk("rst_sel", 32'(sel0), 32'd0);
        chk("rst_data", 32'(data0), 32'd0);
        chk("rst_busy", 32'(busy0), 32'd0);
        chk("rst_done", 32'(done0), 32'd0);
        chk("rst_data1", 32'(data1), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        run_scan(0, 16'h8001, -1, 1'b0);
        for (int k = 0; k < 16; k++) run_scan(0, 16'h0001 << k, -1, 1'b0);
        run_scan(0, 16'h0001, -1, 1'b0);
        run_scan(0, 16'hFFFF, 20, 1'b0);
        run_scan(0, 16'hFFFF, -1, 1'b0);
        run_scan(0, 16'h3C5A, scan_lat(0), 1'b0);

        // start held: two scans back to back, second done two edges past twice the latency
        lat = scan_lat(0);
        mux_i = 16'h1234; dsel = 0;
        @(negedge clk); start_r = 1'b1;
        @(posedge clk);
        cyc = 0; done_cnt = 0; t1 = -1; t2 = -1;
        while (cyc < 2 * lat + 8) begin
            @(negedge clk);
            if (done0) begin
                done_cnt++;
                if (done_cnt == 1) t1 = cyc;
                if (done_cnt == 2) begin t2 = cyc; start_r = 1'b0; end
            end
            @(posedge clk);
            cyc++;
        end
        @(negedge clk); start_r = 1'b0;
        exp_data[0] = 16'h1234;
        chk("hold_done_count", 32'(done_cnt), 32'd2);
        chk("hold_first", 32'(t1), 32'(lat));
        chk("hold_spacing", 32'(t2 - t1), 32'(lat + 2));
        chk("hold_data", 32'(data0), 32'h1234);

        // start and abort together in IDLE
        mux_i = 16'hFFFF;
        start_r = 1'b1; abort_r = 1'b1;
        @(negedge clk); start_r = 1'b0; abort_r = 1'b0;
        bad = 0;
        repeat (5) begin @(negedge clk); if (busy0) bad++; end
        chk("start_abort_idle", 32'(bad), 32'd0);

        run_scan(1, 16'hA5A5, -1, 1'b0);

        // reset during a SETTLE=1 scan
        @(negedge clk); dsel = 1; mux_i = 16'h5A5A; start_r = 1'b1;
        @(posedge clk);
        @(negedge clk); start_r = 1'b0;
        repeat (9) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy1), 32'd0);
        chk("midrst_sel", 32'(sel1), 32'd0);
        chk("midrst_data1", 32'(data1), 32'd0);
        chk("midrst_data0", 32'(data0), 32'd0);
        exp_data[0] = '0; exp_data[1] = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        repeat (40) begin @(negedge clk); if (done1 || busy1) bad++; end
        chk("midrst_no_scan", 32'(bad), 32'd0);

        for (int n = 0; n < 30; n++) begin
            int d, ab;
            d = int'($urandom_range(1, 0));
            ab = ($urandom_range(9, 0) < 3) ? int'($urandom_range(scan_lat(d), 0)) : -1;
            run_scan(d, 16'($urandom), ab, 1'($urandom_range(1, 0)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
